// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer and the datapath muxes it steers.
// Build option MC_CTRL_EXCEPTION_EN (see mc_control_fsm) enables the S_EXC state.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_RWB      = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JAL      = 4'd11,
        S_ADDIEX   = 4'd12,
        S_ADDIWB   = 4'd13,
        S_EXC      = 4'd14
    } state_e;

    localparam logic [1:0] SRCA_PC      = 2'b00;
    localparam logic [1:0] SRCA_A       = 2'b01;
    localparam logic [1:0] SRCA_SEXT    = 2'b10;
    localparam logic [1:0] SRCA_MDR     = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    localparam logic [1:0] M2R_ALUOUT   = 2'b00;
    localparam logic [1:0] M2R_MDR      = 2'b01;
    localparam logic [1:0] M2R_PC       = 2'b10;

    localparam logic [1:0] RDST_RT      = 2'b00;
    localparam logic [1:0] RDST_RD      = 2'b01;
    localparam logic [1:0] RDST_RA      = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       epc_write;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control decoder (Moore); zero latency.
// Only FETCH looks at memory ready, so IR/PC load exactly once per fetched word.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_e     i_state,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut while the opcode dispatches.
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_SEXT_SH;
            end
            S_MEMADDR, S_ADDIEX: begin
                o_ctrl.alu_src_a = SRCA_A;
                o_ctrl.alu_src_b = SRCB_SEXT;
            end
            S_MEMREAD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RT;
                o_ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEMWRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = SRCA_A;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RD;
                o_ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = SRCA_A;
                o_ctrl.alu_src_b     = SRCB_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                // PC already advanced to PC+4 in FETCH, so it is the link value.
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCSRC_JUMP;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RA;
                o_ctrl.mem_to_reg = M2R_PC;
            end
            S_ADDIWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = RDST_RT;
                o_ctrl.mem_to_reg = M2R_ALUOUT;
            end
`ifdef MC_CTRL_EXCEPTION_EN
            S_EXC: begin
                o_ctrl.epc_write = 1'b1;
                o_ctrl.alu_src_a = SRCA_PC;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_EXC;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer; lw 5, sw/R/addi 4, beq/j/jal 3 cycles with zero-wait memory.
// Stalls in FETCH/MEMREAD/MEMWRITE until w_MemReady; MC_CTRL_EXCEPTION_EN adds the EXC state.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         w_Opcode,
    input  logic [5:0]         w_Funct,
    input  logic               w_MemReady,
    input  logic               w_Overflow,
    output logic               w_PCWrite,
    output logic               w_PCWriteCond,
    output logic               w_IorD,
    output logic               w_MemRead,
    output logic               w_MemWrite,
    output logic               w_IRWrite,
    output logic [1:0]         w_MemtoReg,
    output logic [1:0]         w_RegDst,
    output logic               w_RegWrite,
    output logic [1:0]         w_ALUSrcA,
    output logic [1:0]         w_ALUSrcB,
    output logic [1:0]         w_ALUOp,
    output logic [1:0]         w_PCSource,
    output logic               w_EPCWrite,
    output logic [STATE_W-1:0] w_State
);

    state_e r_state;
    state_e w_next;
    ctrl_t  w_ctrl;
    logic   w_unused_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_RESET;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = w_MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADDR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_JAL:       w_next = S_JAL;
                    OP_ADDI:      w_next = S_ADDIEX;
`ifdef MC_CTRL_EXCEPTION_EN
                    default:      w_next = S_EXC;
`else
                    default:      w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADDR: begin
                if (w_Opcode == OP_LW)      w_next = S_MEMREAD;
                else if (w_Opcode == OP_SW) w_next = S_MEMWRITE;
                else                        w_next = S_FETCH;
            end
            S_MEMREAD:  w_next = w_MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next = w_MemReady ? S_FETCH : S_MEMWRITE;
`ifdef MC_CTRL_EXCEPTION_EN
            // Overflow diverts before writeback so the destination register is untouched.
            S_EXEC:     w_next = w_Overflow ? S_EXC : S_RWB;
            S_ADDIEX:   w_next = w_Overflow ? S_EXC : S_ADDIWB;
`else
            S_EXEC:     w_next = S_RWB;
            S_ADDIEX:   w_next = S_ADDIWB;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (w_MemReady),
        .o_ctrl      (w_ctrl)
    );

    assign w_PCWrite     = w_ctrl.pc_write;
    assign w_PCWriteCond = w_ctrl.pc_write_cond;
    assign w_IorD        = w_ctrl.iord;
    assign w_MemRead     = w_ctrl.mem_read;
    assign w_MemWrite    = w_ctrl.mem_write;
    assign w_IRWrite     = w_ctrl.ir_write;
    assign w_MemtoReg    = w_ctrl.mem_to_reg;
    assign w_RegDst      = w_ctrl.reg_dst;
    assign w_RegWrite    = w_ctrl.reg_write;
    assign w_ALUSrcA     = w_ctrl.alu_src_a;
    assign w_ALUSrcB     = w_ctrl.alu_src_b;
    assign w_ALUOp       = w_ctrl.alu_op;
    assign w_PCSource    = w_ctrl.pc_source;
    assign w_State       = STATE_W'(r_state);

    // Funct is consumed by ALU control in the datapath, not by the sequencer.
`ifdef MC_CTRL_EXCEPTION_EN
    assign w_EPCWrite  = w_ctrl.epc_write;
    assign w_unused_ok = ^w_Funct;
`else
    assign w_EPCWrite  = 1'b0;
    assign w_unused_ok = ^{w_Funct, w_Overflow, w_ctrl.epc_write};
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed, table-driven bench for mc_control_fsm (both build options).
module tb_mc_control_fsm;

    logic       clk;
    logic       reset_n;
    logic [5:0] w_Opcode;
    logic [5:0] w_Funct;
    logic       w_MemReady;
    logic       w_Overflow;
    logic       w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite;
    logic [1:0] w_MemtoReg, w_RegDst;
    logic       w_RegWrite;
    logic [1:0] w_ALUSrcA, w_ALUSrcB, w_ALUOp, w_PCSource;
    logic       w_EPCWrite;
    logic [3:0] w_State;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .w_Opcode      (w_Opcode),
        .w_Funct       (w_Funct),
        .w_MemReady    (w_MemReady),
        .w_Overflow    (w_Overflow),
        .w_PCWrite     (w_PCWrite),
        .w_PCWriteCond (w_PCWriteCond),
        .w_IorD        (w_IorD),
        .w_MemRead     (w_MemRead),
        .w_MemWrite    (w_MemWrite),
        .w_IRWrite     (w_IRWrite),
        .w_MemtoReg    (w_MemtoReg),
        .w_RegDst      (w_RegDst),
        .w_RegWrite    (w_RegWrite),
        .w_ALUSrcA     (w_ALUSrcA),
        .w_ALUSrcB     (w_ALUSrcB),
        .w_ALUOp       (w_ALUOp),
        .w_PCSource    (w_PCSource),
        .w_EPCWrite    (w_EPCWrite),
        .w_State       (w_State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] w_outs;
    assign w_outs = {w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_IRWrite,
                     w_MemtoReg, w_RegDst, w_RegWrite, w_ALUSrcA, w_ALUSrcB, w_ALUOp,
                     w_PCSource, w_EPCWrite};

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        ovf;
        logic [3:0]  st;
        logic [19:0] out;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic logic [19:0] pack_o(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic [1:0] m2r, input logic [1:0] rd,
        input logic rw, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop,
        input logic [1:0] ps, input logic epc);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, epc};
    endfunction

    task automatic add(input logic [5:0] op, input logic rdy, input logic ovf,
                       input logic [3:0] st, input logic [19:0] out);
        vec_t v;
        v.op = op; v.rdy = rdy; v.ovf = ovf; v.st = st; v.out = out;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [19:0] O_ZERO, O_FETCH, O_FWAIT, O_DEC, O_MADDR, O_MRD, O_MWB, O_MWR;
    logic [19:0] O_EXEC, O_RWB, O_BR, O_J, O_JAL, O_AEX, O_AWB, O_EXC;

    initial begin
        O_ZERO  = '0;
        O_FETCH = pack_o(1,0,0,1,0,1, 2'd0,2'd0,0, 2'd0,2'd1,2'd0,2'd0, 0);
        O_FWAIT = pack_o(0,0,0,1,0,0, 2'd0,2'd0,0, 2'd0,2'd1,2'd0,2'd0, 0);
        O_DEC   = pack_o(0,0,0,0,0,0, 2'd0,2'd0,0, 2'd0,2'd3,2'd0,2'd0, 0);
        O_MADDR = pack_o(0,0,0,0,0,0, 2'd0,2'd0,0, 2'd1,2'd2,2'd0,2'd0, 0);
        O_MRD   = pack_o(0,0,1,1,0,0, 2'd0,2'd0,0, 2'd0,2'd0,2'd0,2'd0, 0);
        O_MWB   = pack_o(0,0,0,0,0,0, 2'd1,2'd0,1, 2'd0,2'd0,2'd0,2'd0, 0);
        O_MWR   = pack_o(0,0,1,0,1,0, 2'd0,2'd0,0, 2'd0,2'd0,2'd0,2'd0, 0);
        O_EXEC  = pack_o(0,0,0,0,0,0, 2'd0,2'd0,0, 2'd1,2'd0,2'd2,2'd0, 0);
        O_RWB   = pack_o(0,0,0,0,0,0, 2'd0,2'd1,1, 2'd0,2'd0,2'd0,2'd0, 0);
        O_BR    = pack_o(0,1,0,0,0,0, 2'd0,2'd0,0, 2'd1,2'd0,2'd1,2'd1, 0);
        O_J     = pack_o(1,0,0,0,0,0, 2'd0,2'd0,0, 2'd0,2'd0,2'd0,2'd2, 0);
        O_JAL   = pack_o(1,0,0,0,0,0, 2'd2,2'd2,1, 2'd0,2'd0,2'd0,2'd2, 0);
        O_AEX   = pack_o(0,0,0,0,0,0, 2'd0,2'd0,0, 2'd1,2'd2,2'd0,2'd0, 0);
        O_AWB   = pack_o(0,0,0,0,0,0, 2'd0,2'd0,1, 2'd0,2'd0,2'd0,2'd0, 0);
        O_EXC   = pack_o(1,0,0,0,0,0, 2'd0,2'd0,0, 2'd0,2'd1,2'd1,2'd3, 1);

        // R-type add: 1,2,7,8
        add(6'h00, 1, 0, 4'd1,  O_FETCH);
        add(6'h00, 1, 0, 4'd2,  O_DEC);
        add(6'h00, 1, 0, 4'd7,  O_EXEC);
        add(6'h00, 1, 0, 4'd8,  O_RWB);
        // lw: fetch stalls 2 cycles, MEMREAD stalls 3 cycles
        add(6'h23, 0, 0, 4'd1,  O_FWAIT);
        add(6'h23, 0, 0, 4'd1,  O_FWAIT);
        add(6'h23, 1, 0, 4'd1,  O_FETCH);
        add(6'h23, 1, 0, 4'd2,  O_DEC);
        add(6'h23, 1, 0, 4'd3,  O_MADDR);
        add(6'h23, 0, 0, 4'd4,  O_MRD);
        add(6'h23, 0, 0, 4'd4,  O_MRD);
        add(6'h23, 0, 0, 4'd4,  O_MRD);
        add(6'h23, 1, 0, 4'd4,  O_MRD);
        add(6'h23, 1, 0, 4'd5,  O_MWB);
        // sw
        add(6'h2B, 1, 0, 4'd1,  O_FETCH);
        add(6'h2B, 1, 0, 4'd2,  O_DEC);
        add(6'h2B, 1, 0, 4'd3,  O_MADDR);
        add(6'h2B, 1, 0, 4'd6,  O_MWR);
        // beq, j, jal
        add(6'h04, 1, 0, 4'd1,  O_FETCH);
        add(6'h04, 1, 0, 4'd2,  O_DEC);
        add(6'h04, 1, 0, 4'd9,  O_BR);
        add(6'h02, 1, 0, 4'd1,  O_FETCH);
        add(6'h02, 1, 0, 4'd2,  O_DEC);
        add(6'h02, 1, 0, 4'd10, O_J);
        add(6'h03, 1, 0, 4'd1,  O_FETCH);
        add(6'h03, 1, 0, 4'd2,  O_DEC);
        add(6'h03, 1, 0, 4'd11, O_JAL);
        // addi without overflow
        add(6'h08, 1, 0, 4'd1,  O_FETCH);
        add(6'h08, 1, 0, 4'd2,  O_DEC);
        add(6'h08, 1, 0, 4'd12, O_AEX);
        add(6'h08, 1, 0, 4'd13, O_AWB);
        // addi with overflow
        add(6'h08, 1, 0, 4'd1,  O_FETCH);
        add(6'h08, 1, 0, 4'd2,  O_DEC);
        add(6'h08, 1, 1, 4'd12, O_AEX);
`ifdef MC_CTRL_EXCEPTION_EN
        add(6'h08, 1, 0, 4'd14, O_EXC);
`else
        add(6'h08, 1, 0, 4'd13, O_AWB);
`endif
        // undefined opcode
        add(6'h3F, 1, 0, 4'd1,  O_FETCH);
        add(6'h3F, 1, 0, 4'd2,  O_DEC);
`ifdef MC_CTRL_EXCEPTION_EN
        add(6'h3F, 1, 0, 4'd14, O_EXC);
`endif
        add(6'h3F, 0, 0, 4'd1,  O_FWAIT);
    end

    initial begin
        reset_n    = 1'b0;
        w_Opcode   = 6'h00;
        w_Funct    = 6'h20;
        w_MemReady = 1'b0;
        w_Overflow = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(w_State), 32'd0);
        chk("reset_outs",  32'(w_outs),  32'(O_ZERO));
        reset_n = 1'b1;
        #1;
        chk("release_hold_state", 32'(w_State), 32'd0);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            w_Opcode   = vecs[i].op;
            w_MemReady = vecs[i].rdy;
            w_Overflow = vecs[i].ovf;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(w_State), 32'(vecs[i].st));
            chk($sformatf("vec%0d_outs",  i), 32'(w_outs),  32'(vecs[i].out));
        end

        // Reset asserted mid-MEMREAD of an lw aborts at once.
        @(negedge clk);
        w_Opcode = 6'h23; w_MemReady = 1'b1; w_Overflow = 1'b0;
        #1 chk("abort_fetch", 32'(w_State), 32'd1);
        @(negedge clk);
        #1 chk("abort_decode", 32'(w_State), 32'd2);
        @(negedge clk);
        #1 chk("abort_memaddr", 32'(w_State), 32'd3);
        @(negedge clk);
        w_MemReady = 1'b0;
        #1 chk("abort_memread", 32'(w_State), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_async_state", 32'(w_State), 32'd0);
        chk("abort_async_outs",  32'(w_outs),  32'(O_ZERO));
        @(posedge clk);
        @(negedge clk);
        chk("abort_held_state", 32'(w_State), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_refetch_state", 32'(w_State), 32'd1);
        chk("abort_refetch_outs",  32'(w_outs),  32'(O_FWAIT));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle control sequencer for the MIPS datapath. It decodes opcode/funct and steps one instruction through fetch, decode, execute, memory and writeback. Per state it drives every datapath select and enable, including the 2-bit ALUSrcA select consumed by the ALU operand-A mux (00 PC, 01 A, 10 SignExtend, 11 MemDataReg). It stalls on a memory ready handshake.

Parameters:
STATE_W, 4, state register width; must hold all states listed below.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
w_Opcode  in  6  IR[31:26]
w_Funct  in  6  IR[5:0]
w_MemReady  in  1  memory completes the current read/write this cycle
w_Overflow  in  1  ALU signed overflow
w_PCWrite  out  1  unconditional PC load
w_PCWriteCond  out  1  PC load if ALU zero (beq)
w_IorD  out  1  memory address select: 0 PC, 1 ALUOut
w_MemRead  out  1  memory read request
w_MemWrite  out  1  memory write request
w_IRWrite  out  1  instruction register load
w_MemtoReg  out  2  writeback select: 00 ALUOut, 01 MDR, 10 PC
w_RegDst  out  2  destination: 00 rt, 01 rd, 10 r31
w_RegWrite  out  1  register file write
w_ALUSrcA  out  2  00 PC, 01 A, 10 SignExtend, 11 MemDataReg
w_ALUSrcB  out  2  00 B, 01 const 4, 10 SignExt, 11 SignExt<<2
w_ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
w_PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
w_EPCWrite  out  1  EPC load (exception build only)
w_State  out  STATE_W  current state, for debug

Behaviour:
- Reset: asynchronous on reset_n low, the state goes to RESET. Every output is 0 in RESET, including w_State=0.
- Reset release: the first rising edge after reset_n goes high moves RESET to FETCH. Reset mid-instruction aborts it immediately; no write enable stays asserted.
- Outputs are decoded combinationally from the state (Moore). Exceptions are gated by w_MemReady as noted.
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle w_MemReady=1; state then goes to DECODE. Otherwise stay in FETCH.
- DECODE(2): ALUSrcA=00, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on opcode:
  - lw/sw (0x23/0x2B) -> MEMADDR
  - R-type (0x00) -> EXEC
  - beq (0x04) -> BRANCH
  - j (0x02) -> JUMP
  - jal (0x03) -> JAL
  - addi (0x08) -> ADDIEX
  - other -> UNDEF handling, see Optional Feature
- MEMADDR(3): ALUSrcA=01, ALUSrcB=10, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD(4): MemRead=1, IorD=1. Waits for w_MemReady, then -> MEMWB.
- MEMWB(5): RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
- MEMWRITE(6): MemWrite=1, IorD=1. Waits for w_MemReady, then -> FETCH.
- EXEC(7): ALUSrcA=01, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB(8): RegWrite=1, RegDst=01, MemtoReg=00 -> FETCH.
- BRANCH(9): ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP(10): PCWrite=1, PCSource=10 -> FETCH.
- JAL(11): PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 -> FETCH.
  - PC already holds PC+4 when it is written to r31.
- ADDIEX(12): ALUSrcA=01, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB(13): RegWrite=1, RegDst=00, MemtoReg=00 -> FETCH.
- Unused state encodings -> FETCH on the next edge, with all outputs 0.
- Latency (zero-wait memory):
  - lw 5 cycles; sw, R-type and addi 4; beq, j and jal 3.
  - Each w_MemReady=0 cycle adds one cycle.

Optional Feature:
Macro MC_CTRL_EXCEPTION_EN.
- Defined:
  - Undefined opcode in DECODE -> EXC.
  - w_Overflow=1 in EXEC or ADDIEX -> EXC instead of the writeback state, so no register write occurs.
  - EXC(14): EPCWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=01 (PC-4 to EPC), PCWrite=1, PCSource=11 -> FETCH.
- Undefined: no EXC state and w_EPCWrite is tied to 0. Undefined opcodes return to FETCH as a NOP, and overflow is ignored.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI)
  - state encoding constants
  - ALUSrcA/ALUSrcB/ALUOp/PCSource/MemtoReg/RegDst encodings, shared with the datapath muxes
- One sub-module, mc_ctrl_decode: purely combinational state-to-outputs decoder. The top holds the state register and next-state logic.

Test Plan:
- reset_n low mid-MEMREAD (lw) -> all outputs 0 immediately, w_State=0. FETCH one edge after release.
- R-type add, w_MemReady=1 always -> states 1,2,7,8,1. RegWrite=1 only in state 8, with RegDst=01.
- lw with w_MemReady held 0 for 3 cycles in MEMREAD -> MemRead and IorD stay 1, state holds at 4 for 4 cycles, MEMWB follows, MemtoReg=01.
- FETCH with w_MemReady=0 for 2 cycles -> IRWrite and PCWrite stay 0 until the ready cycle, then pulse for exactly 1 cycle.
- beq and jal -> BRANCH drives ALUOp=01 and PCWriteCond=1; JAL drives RegDst=10, MemtoReg=10 and PCSource=10. Each takes 3 cycles total.
- With MC_CTRL_EXCEPTION_EN, opcode 0x3F -> DECODE then EXC (EPCWrite=1, PCSource=11), then FETCH.
  - Without the macro, the same opcode gives DECODE then FETCH with no write enables.
